pu_fifo: RTL and testbench

- Processing-unit-side FIFO: the reader counterpart to accumulator-style PUs.
- Values arrive on the shared data/attr bus under a write signal. They are buffered in order and driven back onto the bus under signal_oe, one per read.
- Provides bus-level value buffering, such as delay lines and reordering slack between PUs, and carries attribute flags (SIGN, OVERFLOW) end to end.

---
 rtl/pu_fifo_pkg.sv | 17 +
 rtl/pu_fifo_if.sv | 24 ++
 rtl/pu_fifo_mem.sv | 26 ++
 rtl/pu_fifo.sv | 135 +++++++++++++
 tb/tb_pu_fifo.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/pu_fifo_pkg.sv
// Shared processing-unit definitions: attribute bit layout, default bus sizing
// and the read-outcome encoding used by the FIFO output stage.
package pu_fifo_pkg;

    localparam int SIGN_BIT       = 0;
    localparam int OVERFLOW_BIT   = 1;
    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_ATTR_WIDTH = 4;
    localparam int DEF_DEPTH      = 4;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_POP   = 2'd1,
        RD_UNDER = 2'd2
    } rd_kind_e;

endpackage

// File: rtl/pu_fifo_if.sv
// Shared PU bus as seen by one FIFO: write/pop strobes, synchronous flush,
// inbound value/attributes and the registered outbound value/attributes.
interface pu_fifo_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ATTR_WIDTH = 4
);
    logic                  signal_clr;
    logic                  signal_wr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [ATTR_WIDTH-1:0] attr_in;
    logic                  signal_oe;
    logic [DATA_WIDTH-1:0] data_out;
    logic [ATTR_WIDTH-1:0] attr_out;

    modport master (
        output signal_clr, signal_wr, data_in, attr_in, signal_oe,
        input  data_out, attr_out
    );

    modport slave (
        input  signal_clr, signal_wr, data_in, attr_in, signal_oe,
        output data_out, attr_out
    );
endinterface

// File: rtl/pu_fifo_mem.sv
// DEPTH x WIDTH register array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
module pu_fifo_mem #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pu_fifo.sv
// PU-side FIFO: buffers {attr, data} pushes in order and replays them onto the
// bus one per read, folding a sticky write-drop error into the OVERFLOW flag.
module pu_fifo
    import pu_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ATTR_WIDTH = DEF_ATTR_WIDTH,
    parameter int SIGN       = SIGN_BIT,
    parameter int OVERFLOW   = OVERFLOW_BIT,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    pu_fifo_if.slave   bus
);

    localparam int EW = ATTR_WIDTH + DATA_WIDTH;
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ATTR_WIDTH-1:0] OVF_MASK = {{(ATTR_WIDTH-1){1'b0}}, 1'b1} << OVERFLOW;

    if (DEPTH < 2 || (1 << ADDR_WIDTH) != DEPTH || SIGN == OVERFLOW ||
        SIGN >= ATTR_WIDTH || OVERFLOW >= ATTR_WIDTH) begin : g_bad_cfg
        $error("pu_fifo: invalid DEPTH/ADDR_WIDTH or attribute index parameters");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [ATTR_WIDTH-1:0] attr_out_q, attr_out_d;

    logic                  full, empty;
    logic                  do_push, do_pop, mem_we;
    rd_kind_e              rd_kind;
    logic [EW-1:0]         head;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // A pop in the same cycle frees a slot, so a push to a full queue is taken.
    assign do_pop  = bus.signal_oe && !empty;
    assign do_push = bus.signal_wr && (!full || do_pop);
    assign mem_we  = do_push && !bus.signal_clr;

    always_comb begin
        rd_kind = RD_IDLE;
        if (bus.signal_oe) begin
            rd_kind = empty ? RD_UNDER : RD_POP;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_d      = err_q;
        data_out_d = '0;
        attr_out_d = '0;

        if (bus.signal_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            err_d    = 1'b0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase

            if (do_pop) begin
                err_d = 1'b0;
            end else if (bus.signal_wr && !do_push) begin
                err_d = 1'b1;
            end

            case (rd_kind)
                RD_POP: begin
                    data_out_d = head[DATA_WIDTH-1:0];
                    attr_out_d = head[EW-1:DATA_WIDTH] | (err_q ? OVF_MASK : '0);
                end
                RD_UNDER: begin
                    attr_out_d = OVF_MASK;
                end
                default: begin
                    data_out_d = '0;
                    attr_out_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            data_out_q <= '0;
            attr_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            data_out_q <= data_out_d;
            attr_out_q <= attr_out_d;
        end
    end

    pu_fifo_mem #(
        .WIDTH      (EW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i ({bus.attr_in, bus.data_in}),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    assign bus.data_out = data_out_q;
    assign bus.attr_out = attr_out_q;

endmodule

// File: tb/tb_pu_fifo.sv
// Directed bench for pu_fifo: a table of one-cycle bus vectors with expected
// registered outputs, plus a hand-written async-reset sequence.
module tb_pu_fifo;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pu_fifo_if #(.DATA_WIDTH(4), .ATTR_WIDTH(4)) bus ();

    pu_fifo #(
        .DATA_WIDTH (4),
        .ATTR_WIDTH (4),
        .SIGN       (0),
        .OVERFLOW   (1),
        .DEPTH      (4),
        .ADDR_WIDTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       wr;
        logic [3:0] din;
        logic [3:0] ain;
        logic       oe;
        logic [3:0] exp_d;
        logic [3:0] exp_a;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic clr, input logic wr, input logic [3:0] din,
                                input logic [3:0] ain, input logic oe,
                                input logic [3:0] exp_d, input logic [3:0] exp_a);
        vec_t v;
        v.clr = clr; v.wr = wr; v.din = din; v.ain = ain; v.oe = oe;
        v.exp_d = exp_d; v.exp_a = exp_a;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic clr, input logic wr, input logic [3:0] din,
                         input logic [3:0] ain, input logic oe);
        bus.signal_clr = clr;
        bus.signal_wr  = wr;
        bus.data_in    = din;
        bus.attr_in    = ain;
        bus.signal_oe  = oe;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);

        // push 3,5,7 then pop with idle gaps
        add(0,1,4'h3,4'h0,0, 4'h0,4'h0);
        add(0,1,4'h5,4'h0,0, 4'h0,4'h0);
        add(0,1,4'h7,4'h0,0, 4'h0,4'h0);
        add(0,0,4'h0,4'h0,1, 4'h3,4'h0);
        add(0,0,4'h0,4'h0,0, 4'h0,4'h0);
        add(0,0,4'h0,4'h0,1, 4'h5,4'h0);
        add(0,0,4'h0,4'h0,0, 4'h0,4'h0);
        add(0,0,4'h0,4'h0,1, 4'h7,4'h0);
        add(0,0,4'h0,4'h0,0, 4'h0,4'h0);
        // overfill: 9 dropped, first pop flags OVERFLOW
        add(0,1,4'h1,4'h0,0, 4'h0,4'h0);
        add(0,1,4'h2,4'h0,0, 4'h0,4'h0);
        add(0,1,4'h3,4'h0,0, 4'h0,4'h0);
        add(0,1,4'h4,4'h0,0, 4'h0,4'h0);
        add(0,1,4'h9,4'h0,0, 4'h0,4'h0);
        add(0,0,4'h0,4'h0,1, 4'h1,4'h2);
        add(0,0,4'h0,4'h0,1, 4'h2,4'h0);
        add(0,0,4'h0,4'h0,1, 4'h3,4'h0);
        add(0,0,4'h0,4'h0,1, 4'h4,4'h0);
        // underflow, then push/pop 6
        add(0,0,4'h0,4'h0,1, 4'h0,4'h2);
        add(0,1,4'h6,4'h0,0, 4'h0,4'h0);
        add(0,0,4'h0,4'h0,1, 4'h6,4'h0);
        // full + simultaneous wr(8)/oe
        add(0,1,4'h1,4'h0,0, 4'h0,4'h0);
        add(0,1,4'h2,4'h0,0, 4'h0,4'h0);
        add(0,1,4'h3,4'h0,0, 4'h0,4'h0);
        add(0,1,4'h4,4'h0,0, 4'h0,4'h0);
        add(0,1,4'h8,4'h0,1, 4'h1,4'h0);
        add(0,0,4'h0,4'h0,1, 4'h2,4'h0);
        add(0,0,4'h0,4'h0,1, 4'h3,4'h0);
        add(0,0,4'h0,4'h0,1, 4'h4,4'h0);
        add(0,0,4'h0,4'h0,1, 4'h8,4'h0);
        add(0,0,4'h0,4'h0,1, 4'h0,4'h2);
        // attribute pass-through, stored OVERFLOW kept
        add(0,1,4'hF,4'h3,0, 4'h0,4'h0);
        add(0,0,4'h0,4'h0,1, 4'hF,4'h3);
        add(0,1,4'hA,4'hD,0, 4'h0,4'h0);
        add(0,0,4'h0,4'h0,1, 4'hA,4'hD);
        // flush wins over same-cycle wr/oe
        add(0,1,4'h1,4'h0,0, 4'h0,4'h0);
        add(0,1,4'h2,4'h0,0, 4'h0,4'h0);
        add(1,1,4'h5,4'h0,1, 4'h0,4'h0);
        add(0,0,4'h0,4'h0,1, 4'h0,4'h2);
        // flush clears sticky error
        add(0,1,4'h1,4'h0,0, 4'h0,4'h0);
        add(0,1,4'h2,4'h0,0, 4'h0,4'h0);
        add(0,1,4'h3,4'h0,0, 4'h0,4'h0);
        add(0,1,4'h4,4'h0,0, 4'h0,4'h0);
        add(0,1,4'h9,4'h0,0, 4'h0,4'h0);
        add(1,0,4'h0,4'h0,0, 4'h0,4'h0);
        add(0,1,4'h5,4'h0,0, 4'h0,4'h0);
        add(0,0,4'h0,4'h0,1, 4'h5,4'h0);
        // empty + simultaneous wr/oe: no bypass
        add(0,1,4'h7,4'h0,1, 4'h0,4'h2);
        add(0,0,4'h0,4'h0,1, 4'h7,4'h0);
        add(0,0,4'h0,4'h0,0, 4'h0,4'h0);

        #12;
        check("reset_data", bus.data_out, 4'h0);
        check("reset_attr", bus.attr_out, 4'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].clr, vecs[i].wr, vecs[i].din, vecs[i].ain, vecs[i].oe);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_data", i), bus.data_out, vecs[i].exp_d);
            check($sformatf("vec%0d_attr", i), bus.attr_out, vecs[i].exp_a);
        end

        // async reset while a pop result is on the bus
        @(negedge clk); drive(0, 1, 4'hB, 4'h0, 0);
        @(negedge clk); drive(0, 1, 4'hC, 4'h0, 0);
        @(negedge clk); drive(0, 0, 4'h0, 4'h0, 1);
        @(posedge clk); #1;
        check("rst_pre_data", bus.data_out, 4'hB);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_data", bus.data_out, 4'h0);
        check("rst_mid_attr", bus.attr_out, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_after_data", bus.data_out, 4'h0);
        check("rst_after_attr", bus.attr_out, 4'h2);
        @(negedge clk); drive(0, 0, 4'h0, 4'h0, 0);
        @(posedge clk); #1;
        check("rst_idle_attr", bus.attr_out, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
